// File: rtl/uart_char_display_if.sv
// Byte stream from the UART receiver plus the display-side synchronous read port
// of the character frame buffer.
interface uart_char_display_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_char;

  modport master (output rx_data, output rx_valid, output rd_addr, input rd_char);
  modport slave  (input rx_data, input rx_valid, input rd_addr, output rd_char);
endinterface

// File: rtl/uart_char_display.sv
// Terminal-style character frame buffer: interprets received ASCII bytes as
// print/cursor commands and serves the buffer to the display through a read port.
module uart_char_display #(
  parameter int COLS   = 16,
  parameter int ROWS   = 2,
  parameter int ADDR_W = 5
) (
  input  logic                                    clk,
  input  logic                                    reset,
  uart_char_display_if.slave                      bus,
  output logic [$clog2(COLS)-1:0]                 cursor_col,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursor_row,
  output logic                                    busy,
  output logic [7:0]                              drop_cnt
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DEPTH = ROWS * COLS;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] clr_addr_r, clr_addr_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic [ROW_W-1:0]  row_r, row_s;
  logic [7:0]        drop_r, drop_s;
  logic              busy_r;
  logic [7:0]        rd_char_r;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [7:0]        wr_data_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [7:0]        mem_r [0:(2**ADDR_W)-1];

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    if (r == ROW_W'(ROWS - 1)) begin
      return {ROW_W{1'b0}};
    end else begin
      return r + ROW_W'(1);
    end
  endfunction

  assign cur_addr_s = ADDR_W'(row_r) * ADDR_W'(COLS) + ADDR_W'(col_r);

  // Next-state, cursor and buffer-write decode
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    col_s      = col_r;
    row_s      = row_r;
    drop_s     = drop_r;
    wr_en_s    = 1'b0;
    wr_addr_s  = cur_addr_s;
    wr_data_s  = 8'h20;
    case (state_r)
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_addr_r;
        if (bus.rx_valid && (drop_r != 8'hFF)) begin
          drop_s = drop_r + 8'd1;
        end else begin
          drop_s = drop_r;
        end
        if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
          state_s    = ST_IDLE;
          clr_addr_s = {ADDR_W{1'b0}};
          col_s      = {COL_W{1'b0}};
          row_s      = {ROW_W{1'b0}};
        end else begin
          clr_addr_s = clr_addr_r + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (!bus.rx_valid) begin
          state_s = ST_IDLE;
        end else if ((bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E)) begin
          wr_en_s   = 1'b1;
          wr_data_s = bus.rx_data;
          if (col_r == COL_W'(COLS - 1)) begin
            col_s = {COL_W{1'b0}};
            row_s = row_inc(row_r);
          end else begin
            col_s = col_r + COL_W'(1);
          end
        end else begin
          case (bus.rx_data)
            8'h0D: col_s = {COL_W{1'b0}};
            8'h0A: row_s = row_inc(row_r);
            8'h08: begin
              // Backspace never wraps back onto the previous row
              if (col_r != {COL_W{1'b0}}) begin
                col_s     = col_r - COL_W'(1);
                wr_en_s   = 1'b1;
                wr_addr_s = cur_addr_s - ADDR_W'(1);
              end else begin
                col_s = col_r;
              end
            end
            8'h1B: begin
              state_s    = ST_CLEAR;
              clr_addr_s = {ADDR_W{1'b0}};
            end
            default: state_s = ST_IDLE;
          endcase
        end
      end
      default: begin
        state_s    = ST_CLEAR;
        clr_addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control and cursor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= {ADDR_W{1'b0}};
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      drop_r     <= 8'h00;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      clr_addr_r <= clr_addr_s;
      col_r      <= col_s;
      row_r      <= row_s;
      drop_r     <= drop_s;
      busy_r     <= (state_s == ST_CLEAR);
    end
  end

  // Buffer write port; contents are initialised by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Read port: old data on a same-address write, blanks outside the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_char_r <= 8'h20;
    end else if (int'(bus.rd_addr) < DEPTH) begin
      rd_char_r <= mem_r[bus.rd_addr];
    end else begin
      rd_char_r <= 8'h20;
    end
  end

  assign bus.rd_char = rd_char_r;
  assign cursor_col  = col_r;
  assign cursor_row  = row_r;
  assign busy        = busy_r;
  assign drop_cnt    = drop_r;

endmodule

// File: tb/tb_uart_char_display.sv
// Self-checking bench for uart_char_display: directed scenarios plus random
// traffic compared against a behavioural frame-buffer/cursor model.
module tb_uart_char_display;

  localparam int COLS  = 16;
  localparam int ROWS  = 2;
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = 6;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cursor_col;
  logic [0:0] cursor_row;
  logic       busy;
  logic [7:0] drop_cnt;

  uart_char_display_if #(.ADDR_W(AW)) bus ();

  uart_char_display #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  int         m_col, m_row, m_clr, m_drop;
  logic [7:0] exp_rd;
  bit         exp_known;

  task automatic model_reset();
    m_clr  = DEPTH;
    m_drop = 0;
    m_col  = 0;
    m_row  = 0;
  endtask

  task automatic m_apply(input logic [7:0] d, input bit v);
    int idx;
    if (m_clr > 0) begin
      idx = DEPTH - m_clr;
      m_mem[idx] = 8'h20;
      m_known[idx] = 1'b1;
      if (v && m_drop < 255) m_drop++;
      m_clr--;
      if (m_clr == 0) begin
        m_col = 0;
        m_row = 0;
      end
    end else if (v) begin
      if (d >= 8'h20 && d <= 8'h7E) begin
        idx = m_row * COLS + m_col;
        m_mem[idx] = d;
        m_known[idx] = 1'b1;
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end
      end else begin
        case (d)
          8'h0D: m_col = 0;
          8'h0A: m_row = (m_row + 1) % ROWS;
          8'h08: if (m_col > 0) begin
            m_col--;
            m_mem[m_row * COLS + m_col] = 8'h20;
            m_known[m_row * COLS + m_col] = 1'b1;
          end
          8'h1B: m_clr = DEPTH;
          default: ;
        endcase
      end
    end
  endtask

  // One clock: drive at negedge, model the edge, return at posedge+1
  task automatic step(input logic [7:0] d, input bit v, input int a);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = v;
    bus.rd_addr  = AW'(a);
    if (a >= DEPTH) begin
      exp_rd = 8'h20;
      exp_known = 1'b1;
    end else begin
      exp_rd = m_mem[a];
      exp_known = m_known[a];
    end
    m_apply(d, v);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(d, 1'b1, 0);
  endtask

  task automatic wait_clear();
    while (m_clr > 0) step(8'h00, 1'b0, 0);
  endtask

  task automatic test_reset();
    int n;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b expected 1", busy); end
    n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL reset_rd_char: got %0h expected 20", bus.rd_char); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    n_checks++; if (cursor_col !== 4'd0 || cursor_row !== 1'b0) begin n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
    reset = 1'b0;
    n = 0;
    do begin
      step(8'h00, 1'b0, n % DEPTH);
      n++;
    end while (busy === 1'b1 && n < 100);
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL reset_busy_len: got %0d expected %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      step(8'h00, 1'b0, i);
      n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL reset_blank[%0d]: got %0h expected 20", i, bus.rd_char); end
    end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_after: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_hi();
    send(8'h48);
    send(8'h49);
    n_checks++; if (cursor_row !== 1'b0 || cursor_col !== 4'd2) begin n_fail++; $display("FAIL hi_cursor: got (%0d,%0d) expected (0,2)", cursor_row, cursor_col); end
    step(8'h00, 1'b0, 1);
    n_checks++; if (bus.rd_char !== 8'h49) begin n_fail++; $display("FAIL hi_rd1: got %0h expected 49", bus.rd_char); end
    step(8'h00, 1'b0, 0);
    n_checks++; if (bus.rd_char !== 8'h48) begin n_fail++; $display("FAIL hi_rd0: got %0h expected 48", bus.rd_char); end
  endtask

  task automatic test_wrap();
    send(8'h1B);
    wait_clear();
    for (int i = 0; i < 17; i++) send(8'h41 + 8'(i));
    n_checks++; if (cursor_row !== 1'b1 || cursor_col !== 4'd1) begin n_fail++; $display("FAIL wrap17_cursor: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    step(8'h00, 1'b0, 15);
    n_checks++; if (bus.rd_char !== 8'h50) begin n_fail++; $display("FAIL wrap_addr15: got %0h expected 50", bus.rd_char); end
    step(8'h00, 1'b0, 16);
    n_checks++; if (bus.rd_char !== 8'h51) begin n_fail++; $display("FAIL wrap_addr16: got %0h expected 51", bus.rd_char); end
    for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
    n_checks++; if (cursor_row !== 1'b0 || cursor_col !== 4'd1) begin n_fail++; $display("FAIL wrap33_cursor: got (%0d,%0d) expected (0,1)", cursor_row, cursor_col); end
    step(8'h00, 1'b0, 0);
    n_checks++; if (bus.rd_char !== 8'h70) begin n_fail++; $display("FAIL wrap_addr0: got %0h expected 70", bus.rd_char); end
  endtask

  task automatic test_backspace();
    send(8'h1B);
    wait_clear();
    send(8'h41); send(8'h42); send(8'h08); send(8'h08); send(8'h08);
    n_checks++; if (cursor_row !== 1'b0 || cursor_col !== 4'd0) begin n_fail++; $display("FAIL bs_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
    step(8'h00, 1'b0, 0);
    n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL bs_addr0: got %0h expected 20", bus.rd_char); end
    step(8'h00, 1'b0, 1);
    n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL bs_addr1: got %0h expected 20", bus.rd_char); end
  endtask

  task automatic test_cr_lf();
    send(8'h41); send(8'h42); send(8'h0D); send(8'h0A); send(8'h43);
    n_checks++; if (cursor_row !== 1'b1 || cursor_col !== 4'd1) begin n_fail++; $display("FAIL crlf_cursor: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    step(8'h00, 1'b0, 16);
    n_checks++; if (bus.rd_char !== 8'h43) begin n_fail++; $display("FAIL crlf_addr16: got %0h expected 43", bus.rd_char); end
    send(8'h07);
    n_checks++; if (cursor_row !== 1'b1 || cursor_col !== 4'd1 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL bell_nochange: got (%0d,%0d) busy %0b drop %0d expected (1,1) busy 0 drop 0", cursor_row, cursor_col, busy, drop_cnt);
    end
  endtask

  task automatic test_esc_drop();
    int n;
    send(8'h1B);
    for (int i = 0; i < 3; i++) send(8'h58);
    n = 4;
    while (busy === 1'b1 && n < 100) begin
      n_checks++; if (cursor_row !== 1'b1 || cursor_col !== 4'd1) begin n_fail++; $display("FAIL esc_cursor_hold: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
      step(8'h00, 1'b0, 0);
      n++;
    end
    n_checks++; if (n != DEPTH + 1) begin n_fail++; $display("FAIL esc_busy_len: got %0d expected %0d", n - 1, DEPTH); end
    n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL esc_drop: got %0d expected 3", drop_cnt); end
    n_checks++; if (cursor_row !== 1'b0 || cursor_col !== 4'd0) begin n_fail++; $display("FAIL esc_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
    for (int i = 0; i < DEPTH; i++) begin
      step(8'h00, 1'b0, i);
      n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL esc_blank[%0d]: got %0h expected 20", i, bus.rd_char); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(8'h41);
    send(8'h1B);
    for (int i = 0; i < 5; i++) send(8'h5A);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got drop %0d busy %0b expected drop 0 busy 1", drop_cnt, busy); end
    reset = 1'b0;
    n = 0;
    do begin
      step(8'h00, 1'b0, 0);
      n++;
    end while (busy === 1'b1 && n < 100);
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL mid_busy_len: got %0d expected %0d", n, DEPTH); end
    step(8'h00, 1'b0, 0);
    n_checks++; if (bus.rd_char !== 8'h20) begin n_fail++; $display("FAIL mid_addr0: got %0h expected 20", bus.rd_char); end
  endtask

  task automatic test_drop_saturate();
    for (int k = 0; k < 9; k++) begin
      send(8'h1B);
      while (m_clr > 0) step(8'h41, 1'b1, 0);
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      d = 8'($urandom_range(32'h20, 32'h7E));
      else if (r < 70) d = 8'h0D;
      else if (r < 78) d = 8'h0A;
      else if (r < 90) d = 8'h08;
      else if (r < 91) d = 8'h1B;
      else             d = 8'($urandom_range(0, 255));
      step(d, ($urandom_range(0, 9) < 8), $urandom_range(0, 63));
      n_checks++; if (busy !== (m_clr > 0)) begin n_fail++; $display("FAIL rnd_busy @%0d: got %0b expected %0b", i, busy, (m_clr > 0)); end
      n_checks++; if (cursor_col !== 4'(m_col) || cursor_row !== 1'(m_row)) begin
        n_fail++; $display("FAIL rnd_cursor @%0d: got (%0d,%0d) expected (%0d,%0d)", i, cursor_row, cursor_col, m_row, m_col);
      end
      n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop @%0d: got %0d expected %0d", i, drop_cnt, m_drop); end
      if (exp_known) begin
        n_checks++; if (bus.rd_char !== exp_rd) begin n_fail++; $display("FAIL rnd_rd @%0d: got %0h expected %0h", i, bus.rd_char, exp_rd); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end
    test_reset();
    test_hi();
    test_wrap();
    test_backspace();
    test_cr_lf();
    test_esc_drop();
    test_reset_mid();
    test_drop_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
